// File: rtl/pong_pkg.sv
// Shared constants for the pong serve/score sequencing: state encoding, serve direction
// and goal decoding.
package pong_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StCountdown = 3'd0;
    localparam state_t StServe     = 3'd1;
    localparam state_t StPlay      = 3'd2;
    localparam state_t StScored    = 3'd3;
    localparam state_t StDone      = 3'd4;

    localparam int unsigned WinScoreDefault = 6;

    localparam logic DirP1 = 1'b0;
    localparam logic DirP2 = 1'b1;

    typedef enum logic [1:0] {
        GoalNone = 2'b00,
        GoalP1   = 2'b01,
        GoalP2   = 2'b10,
        GoalBoth = 2'b11
    } goal_e;

    function automatic goal_e decode_goal(input logic goal_p1, input logic goal_p2);
        return goal_e'({goal_p2, goal_p1});
    endfunction

endpackage

// File: rtl/serve_controller_if.sv
// Signal bundle between the serve controller and the game-state / ball / display logic.
interface serve_controller_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               game_active;
    logic               goal_p1;
    logic               goal_p2;
    logic               serve_ack;
    logic               serve_req;
    logic               serve_dir;
    logic               ball_reset;
    logic               ball_run;
    logic [SCORE_W-1:0] scoreP1;
    logic [SCORE_W-1:0] scoreP2;
    logic [3:0]         countdown;
    logic               match_over;

    modport master (
        input  game_active, goal_p1, goal_p2, serve_ack,
        output serve_req, serve_dir, ball_reset, ball_run,
        output scoreP1, scoreP2, countdown, match_over
    );

    modport slave (
        output game_active, goal_p1, goal_p2, serve_ack,
        input  serve_req, serve_dir, ball_reset, ball_run,
        input  scoreP1, scoreP2, countdown, match_over
    );
endinterface

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_divider #(
    parameter int unsigned TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en & (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serve_controller.sv
// Point sequencer: countdown, serve handshake, live play, goal scoring and match end.
// Holds the authoritative scores; all sequencing freezes while game_active is low.
module serve_controller
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV          = 1_000_000,
    parameter int unsigned SERVE_DELAY_TICKS = 3,
    parameter int unsigned WIN_SCORE         = WinScoreDefault,
    parameter int unsigned SCORE_W           = 4
) (
    input logic               clk,
    input logic               reset,
    serve_controller_if.master bus
);
    localparam logic [3:0]         DelayInit = 4'(SERVE_DELAY_TICKS);
    localparam logic [SCORE_W-1:0] WinVal    = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [3:0]         countdown_q, countdown_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               dir_q, dir_d;
    logic               tick, tick_en, tick_clear;
    logic               win;
    goal_e              goal;

    assign goal = decode_goal(bus.goal_p1, bus.goal_p2);
    assign win  = (score_p1_q == WinVal) || (score_p2_q == WinVal);

    // The counter restarts from zero whenever a fresh countdown begins after a point.
    assign tick_en    = (state_q == StCountdown) & bus.game_active;
    assign tick_clear = (state_q == StScored) & bus.game_active;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .reset(reset),
        .en   (tick_en),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        countdown_d = countdown_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        dir_d       = dir_q;
        if (bus.game_active) begin
            case (state_q)
                StCountdown: begin
                    if (tick) begin
                        if (countdown_q > 4'd1) begin
                            countdown_d = countdown_q - 4'd1;
                        end else begin
                            countdown_d = 4'd0;
                            state_d     = StServe;
                        end
                    end
                end
                StServe: begin
                    if (bus.serve_ack) state_d = StPlay;
                end
                StPlay: begin
                    // Next serve goes toward the player who conceded.
                    case (goal)
                        GoalP1: begin
                            state_d    = StScored;
                            score_p1_d = (score_p1_q >= WinVal) ? score_p1_q : score_p1_q + 1'b1;
                            dir_d      = DirP2;
                        end
                        GoalP2: begin
                            state_d    = StScored;
                            score_p2_d = (score_p2_q >= WinVal) ? score_p2_q : score_p2_q + 1'b1;
                            dir_d      = DirP1;
                        end
                        GoalBoth: state_d = StScored;
                        default: ;
                    endcase
                end
                StScored: begin
                    if (win) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StCountdown;
                        countdown_d = DelayInit;
                    end
                end
                StDone: ;
                default: begin
                    state_d     = StCountdown;
                    countdown_d = DelayInit;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StCountdown;
            countdown_q <= DelayInit;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            dir_q       <= DirP1;
        end else begin
            state_q     <= state_d;
            countdown_q <= countdown_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            dir_q       <= dir_d;
        end
    end

    assign bus.serve_req  = (state_q == StServe);
    assign bus.ball_reset = (state_q == StCountdown) || (state_q == StScored) ||
                            (state_q == StDone);
    assign bus.ball_run   = (state_q == StPlay) & bus.game_active;
    assign bus.match_over = (state_q == StDone);
    assign bus.serve_dir  = dir_q;
    assign bus.countdown  = countdown_q;
    assign bus.scoreP1    = score_p1_q;
    assign bus.scoreP2    = score_p2_q;

endmodule

// File: tb/tb_serve_controller.sv
// Randomized scoreboard bench: the driver scripts each point and queues the expected outputs,
// a negedge monitor pops and compares them.
module tb_serve_controller;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned Delay    = 3;
    localparam int unsigned Win      = 6;

    typedef struct packed {
        logic [3:0] cd;
        logic       req;
        logic       dir;
        logic       brst;
        logic       brun;
        logic       mo;
        logic [3:0] s1;
        logic [3:0] s2;
    } obs_t;

    typedef struct {
        bit   skip;
        obs_t o;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   total;
    int   bad;
    int   cyc;

    // Reference score/direction state
    int   s1;
    int   s2;
    bit   dir;

    int   m0_kinds[9] = '{1, 2, 3, 1, 2, 1, 1, 1, 1};

    serve_controller_if #(.SCORE_W(4)) bus ();

    serve_controller #(
        .TICK_DIV         (TickDiv),
        .SERVE_DELAY_TICKS(Delay),
        .WIN_SCORE        (Win),
        .SCORE_W          (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit coin(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic obs_t mk(input int cd, input bit req, input bit brst, input bit brun,
                                input bit mo);
        obs_t o;
        o.cd   = 4'(cd);
        o.req  = req;
        o.dir  = dir;
        o.brst = brst;
        o.brun = brun;
        o.mo   = mo;
        o.s1   = 4'(s1);
        o.s2   = 4'(s2);
        return o;
    endfunction

    task automatic drive(input bit rst, input bit ga, input bit g1, input bit g2, input bit ack,
                         input bit skip, input obs_t o);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.game_active = ga;
        bus.goal_p1     = g1;
        bus.goal_p2     = g2;
        bus.serve_ack   = ack;
        e.skip = skip;
        e.o    = o;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        drive(1'b1, coin(50), coin(30), coin(30), coin(30), 1'b1, '0);
        s1  = 0;
        s2  = 0;
        dir = 1'b0;
    endtask

    // Needs Delay*TickDiv active cycles; countdown drops every TickDiv active cycles.
    task automatic countdown_phase(input bit freeze_test);
        int active = 0;
        int frozen = 0;
        bit ga;
        while (active < int'(Delay * TickDiv)) begin
            ga = coin(88);
            if (freeze_test && active == 5 && frozen < 10) begin
                ga = 1'b0;
                frozen++;
            end
            drive(1'b0, ga, coin(12), coin(12), coin(12), 1'b0,
                  mk(int'(Delay) - active / int'(TickDiv), 1'b0, 1'b1, 1'b0, 1'b0));
            if (ga) active++;
        end
    endtask

    task automatic serve_phase(input int d);
        int waited = 0;
        bit done = 1'b0;
        bit ga;
        bit ack;
        while (!done) begin
            ga  = coin(88);
            ack = (waited >= d);
            drive(1'b0, ga, coin(15), coin(15), ack, 1'b0, mk(0, 1'b1, 1'b0, 1'b0, 1'b0));
            if (ga && ack) done = 1'b1;
            waited++;
        end
    endtask

    task automatic play_phase(input int len, input int kind, input int abort_at,
                              output bit aborted);
        int n = 0;
        bit done = 1'b0;
        bit ga;
        bit fire;
        aborted = 1'b0;
        while (!done) begin
            if (n == abort_at) begin
                do_reset();
                aborted = 1'b1;
                return;
            end
            ga   = coin(88);
            fire = (n >= len);
            drive(1'b0, ga, fire && kind != 2, fire && kind != 1, coin(20), 1'b0,
                  mk(0, 1'b0, 1'b0, ga, 1'b0));
            if (fire && ga) done = 1'b1;
            n++;
        end
    endtask

    task automatic scored_phase();
        bit ga;
        do begin
            ga = coin(75);
            drive(1'b0, ga, coin(30), coin(30), coin(30), 1'b0, mk(0, 1'b0, 1'b1, 1'b0, 1'b0));
        end while (!ga);
    endtask

    task automatic done_phase();
        repeat (8) begin
            drive(1'b0, coin(70), coin(40), coin(40), coin(50), 1'b0,
                  mk(0, 1'b0, 1'b1, 1'b0, 1'b1));
        end
    endtask

    function automatic int pick_kind();
        int r = $urandom_range(0, 99);
        if (r < 50) return 1;
        if (r < 80) return 2;
        return 3;
    endfunction

    task automatic run_match(input int m);
        int pt = 0;
        bit fin = 1'b0;
        bit ab;
        int kind;
        int len;
        do_reset();
        while (!fin) begin
            countdown_phase(m == 0 && pt == 0);
            serve_phase((m == 0 && pt == 0) ? 5 : $urandom_range(0, 4));
            kind = (m == 0) ? m0_kinds[pt] : pick_kind();
            len  = $urandom_range(2, 6);
            play_phase(len, kind, (m == 2 && pt == 2) ? 1 : -1, ab);
            if (ab) return;
            if (kind == 1) begin
                s1  = (s1 < int'(Win)) ? s1 + 1 : s1;
                dir = 1'b1;
            end else if (kind == 2) begin
                s2  = (s2 < int'(Win)) ? s2 + 1 : s2;
                dir = 1'b0;
            end
            scored_phase();
            if (s1 == int'(Win) || s2 == int'(Win)) begin
                done_phase();
                fin = 1'b1;
            end
            pt++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        obs_t act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.skip) begin
                act.cd   = bus.countdown;
                act.req  = bus.serve_req;
                act.dir  = bus.serve_dir;
                act.brst = bus.ball_reset;
                act.brun = bus.ball_run;
                act.mo   = bus.match_over;
                act.s1   = bus.scoreP1;
                act.s2   = bus.scoreP2;
                total++;
                if (act !== e.o) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got cd=%0d req=%b dir=%b rst=%b run=%b mo=%b s=%0d:%0d exp cd=%0d req=%b dir=%b rst=%b run=%b mo=%b s=%0d:%0d",
                             cyc, act.cd, act.req, act.dir, act.brst, act.brun, act.mo,
                             act.s1, act.s2, e.o.cd, e.o.req, e.o.dir, e.o.brst, e.o.brun,
                             e.o.mo, e.o.s1, e.o.s2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total           = 0;
        bad             = 0;
        cyc             = 0;
        s1              = 0;
        s2              = 0;
        dir             = 1'b0;
        reset           = 1'b1;
        bus.game_active = 1'b0;
        bus.goal_p1     = 1'b0;
        bus.goal_p2     = 1'b0;
        bus.serve_ack   = 1'b0;
        for (int m = 0; m < 4; m++) begin
            run_match(m);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        @(negedge clk);
        @(negedge clk);
        if (total < 12) begin
            bad++;
            $display("FAIL check_count got=%0d required>=12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
